// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - LEGv8 load-use stall / taken-branch flush control FSM.
// Optional saturating stall/flush counters enabled by PIPELINE_CONTROL_PERF_COUNTERS_EN.
module pipeline_control_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  id_rn,
   input  logic [4:0]  id_rm,
   input  logic        id_uses_rm,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rd,
   input  logic        mem_branch_taken,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_ex_bubble,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        flush_ex_mem,
   output logic        pc_src,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   state_t state_q, state_d;
   logic   hazard;

   // XZR reads as zero, so a load targeting it can never feed a consumer.
   assign hazard = ex_memread && (ex_rd != 5'd31) &&
                   ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      pc_src       = 1'b0;
      state_d      = RUN;
      if (!reset) begin
         state_d = RUN;
      end else if (mem_branch_taken) begin
         // A taken branch squashes the dependent instruction, so no bubble is needed.
         pc_src       = 1'b1;
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
         flush_ex_mem = 1'b1;
         state_d      = FLUSH;
      end else if ((state_q != STALL) && hazard) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         state_d      = STALL;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef PIPELINE_CONTROL_PERF_COUNTERS_EN
   logic [15:0] stall_count_q, stall_count_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (id_ex_bubble && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
      if (reset && mem_branch_taken && (flush_count_q != 16'hFFFF)) begin
         flush_count_d = flush_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_count_q <= 16'd0;
         flush_count_q <= 16'd0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`else
   assign stall_count = 16'd0;
   assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - scoreboard bench for pipeline_control_unit.
module tb_pipeline_control_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  id_rn = '0, id_rm = '0, ex_rd = '0;
   logic        id_uses_rm = 1'b0, ex_memread = 1'b0, mem_branch_taken = 1'b0;
   logic        pc_write, if_id_write, id_ex_bubble;
   logic        flush_if_id, flush_id_ex, flush_ex_mem, pc_src;
   logic [15:0] stall_count, flush_count;

   pipeline_control_unit dut (
      .clock(clock), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
      .pc_src(pc_src), .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       rstn;
      logic [4:0] rn;
      logic [4:0] rm;
      logic       uses_rm;
      logic       memread;
      logic [4:0] rd;
      logic       br;
   } stim_t;

   typedef struct packed {
      logic [6:0]  ctl;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   // ctl = {pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, pc_src}
   localparam logic [6:0] DEF = 7'b1100000;
   localparam logic [6:0] BUB = 7'b0010000;
   localparam logic [6:0] BRF = 7'b1101111;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_sc = 16'd0;
   logic [15:0] exp_fc = 16'd0;

   function automatic stim_t mk(input logic rstn, input logic [4:0] rn, input logic [4:0] rm,
                                input logic uses_rm, input logic memread, input logic [4:0] rd,
                                input logic br);
      stim_t s;
      s = {rstn, rn, rm, uses_rm, memread, rd, br};
      return s;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o.ctl = {pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, pc_src};
      o.sc  = stall_count;
      o.fc  = flush_count;
      return o;
   endfunction

   // Drives one cycle of stimulus at the falling edge and queues what the outputs must show.
   task automatic drive(input stim_t s, input logic [6:0] ctl);
      exp_t e;
      @(negedge clock);
      reset = s.rstn; id_rn = s.rn; id_rm = s.rm; id_uses_rm = s.uses_rm;
      ex_memread = s.memread; ex_rd = s.rd; mem_branch_taken = s.br;
      if (!s.rstn) begin
         exp_sc = 16'd0;
         exp_fc = 16'd0;
      end
      e.ctl = ctl;
      e.sc  = exp_sc;
      e.fc  = exp_fc;
      sb.push_back(e);
`ifdef PIPELINE_CONTROL_PERF_COUNTERS_EN
      if (s.rstn && ctl[4]) exp_sc = sat_inc(exp_sc);
      if (s.rstn && s.br) exp_fc = sat_inc(exp_fc);
`endif
      #1;
   endtask

   task automatic test_reset();
      stim_t st[3];
      exp_t  e, o;
      st[0] = mk(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1);
      st[1] = mk(1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
      st[2] = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(st[i], DEF);
         e = sb.pop_front(); o = observed(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset[%0d] got ctl=%b sc=%h fc=%h want ctl=%b sc=%h fc=%h", i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
         end
      end
   endtask

   task automatic test_load_use();
      stim_t      st[3];
      logic [6:0] ex[3];
      exp_t       e, o;
      st[0] = mk(1'b1, 5'd16, 5'd2, 1'b0, 1'b1, 5'd16, 1'b0); ex[0] = BUB;
      st[1] = st[0];                                           ex[1] = DEF;
      st[2] = mk(1'b1, 5'd16, 5'd2, 1'b0, 1'b0, 5'd4, 1'b0);  ex[2] = DEF;
      for (int i = 0; i < 3; i++) begin
         drive(st[i], ex[i]);
         e = sb.pop_front(); o = observed(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL load_use[%0d] got ctl=%b sc=%h fc=%h want ctl=%b sc=%h fc=%h", i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
         end
      end
   endtask

   task automatic test_rm_and_xzr();
      stim_t      st[6];
      logic [6:0] ex[6];
      exp_t       e, o;
      st[0] = mk(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0); ex[0] = DEF;
      st[1] = mk(1'b1, 5'd1,  5'd5,  1'b0, 1'b1, 5'd5,  1'b0); ex[1] = DEF;
      st[2] = mk(1'b1, 5'd1,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0); ex[2] = BUB;
      st[3] = st[2];                                            ex[3] = DEF;
      st[4] = mk(1'b1, 5'd9,  5'd9,  1'b1, 1'b0, 5'd9,  1'b0); ex[4] = DEF;
      st[5] = mk(1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0); ex[5] = BUB;
      for (int i = 0; i < 6; i++) begin
         drive(st[i], ex[i]);
         e = sb.pop_front(); o = observed(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL rm_xzr[%0d] got ctl=%b sc=%h fc=%h want ctl=%b sc=%h fc=%h", i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
         end
      end
      drive(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0), DEF);
      void'(sb.pop_front());
   endtask

   task automatic test_branch();
      stim_t      st[2];
      logic [6:0] ex[2];
      exp_t       e, o;
      st[0] = mk(1'b1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd8, 1'b1); ex[0] = BRF;
      st[1] = mk(1'b1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd8, 1'b0); ex[1] = DEF;
      for (int i = 0; i < 2; i++) begin
         drive(st[i], ex[i]);
         e = sb.pop_front(); o = observed(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL branch[%0d] got ctl=%b sc=%h fc=%h want ctl=%b sc=%h fc=%h", i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t      st[6];
      logic [6:0] ex[6];
      exp_t       e, o;
      st[0] = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);  ex[0] = BRF;
      st[1] = st[0];                                          ex[1] = BRF;
      st[2] = st[0];                                          ex[2] = BRF;
      st[3] = mk(1'b1, 5'd12, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0); ex[3] = BUB;
      st[4] = mk(1'b1, 5'd12, 5'd0, 1'b0, 1'b1, 5'd12, 1'b1); ex[4] = BRF;
      st[5] = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0);   ex[5] = DEF;
      for (int i = 0; i < 6; i++) begin
         drive(st[i], ex[i]);
         e = sb.pop_front(); o = observed(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL back_to_back[%0d] got ctl=%b sc=%h fc=%h want ctl=%b sc=%h fc=%h", i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
         end
      end
   endtask

   task automatic test_simultaneous();
      stim_t      st[4];
      logic [6:0] ex[4];
      exp_t       e, o;
      st[0] = mk(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 5'd21, 1'b1); ex[0] = BRF;
      st[1] = mk(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 5'd21, 1'b0); ex[1] = BUB;
      st[2] = st[1];                                            ex[2] = DEF;
      st[3] = mk(1'b1, 5'd20, 5'd21, 1'b1, 1'b0, 5'd21, 1'b0); ex[3] = DEF;
      for (int i = 0; i < 4; i++) begin
         drive(st[i], ex[i]);
         e = sb.pop_front(); o = observed(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL simultaneous[%0d] got ctl=%b sc=%h fc=%h want ctl=%b sc=%h fc=%h", i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t      st[5];
      logic [6:0] ex[5];
      exp_t       e, o;
      st[0] = mk(1'b1, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0); ex[0] = BUB;
      st[1] = mk(1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1); ex[1] = DEF;
      st[2] = mk(1'b1, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0); ex[2] = BUB;
      st[3] = mk(1'b1, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1); ex[3] = BRF;
      st[4] = mk(1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1); ex[4] = DEF;
      for (int i = 0; i < 5; i++) begin
         drive(st[i], ex[i]);
         e = sb.pop_front(); o = observed(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset_mid_op[%0d] got ctl=%b sc=%h fc=%h want ctl=%b sc=%h fc=%h", i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
         end
      end
      drive(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0), DEF);
      void'(sb.pop_front());
   endtask

`ifdef PIPELINE_CONTROL_PERF_COUNTERS_EN
   task automatic test_saturation();
      stim_t hz, idle;
      exp_t  e, o;
      hz   = mk(1'b1, 5'd10, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0);
      idle = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0);
      @(negedge clock);
      dut.stall_count_q = 16'hFFFE;
      exp_sc = 16'hFFFE;
      for (int i = 0; i < 4; i++) begin
         drive(hz, BUB);
         void'(sb.pop_front());
         drive(i == 3 ? idle : hz, DEF);
         e = sb.pop_front(); o = observed(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL saturation[%0d] got ctl=%b sc=%h fc=%h want ctl=%b sc=%h fc=%h", i, o.ctl, o.sc, o.fc, e.ctl, e.sc, e.fc);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_rm_and_xzr();
      test_branch();
      test_back_to_back();
      test_simultaneous();
      test_reset_mid_stall();
`ifdef PIPELINE_CONTROL_PERF_COUNTERS_EN
      test_saturation();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning (clock and reset first).
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_rn  input  5  Rn field of the instruction in ID.
- id_rm  input  5  Rm/Rt field of the instruction in ID.
- id_uses_rm  input  1  the ID instruction reads id_rm (R-type, STUR, CBZ/CBNZ Rt).
- ex_memread  input  1  the EX instruction is a load (LDUR).
- ex_rd  input  5  destination register of the EX instruction.
- mem_branch_taken  input  1  CBZ/CBNZ/B resolved taken in MEM.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register load enable.
- id_ex_bubble  output  1  force ID/EX control fields to zero.
- flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  squash the named pipeline register.
- pc_src  output  1  select branch target for the next PC.
- stall_count, flush_count  output  16 each  performance counters (see Configuration).

Function
REQ-002 The FSM SHALL have three states: RUN, STALL, FLUSH; encoding is free.
REQ-003 hazard = ex_memread AND ex_rd != 31 AND (ex_rd == id_rn OR (id_uses_rm AND ex_rd == id_rm)); X31 (XZR) SHALL never raise a hazard.
REQ-004 Outputs SHALL be combinational from the current state and inputs; the state SHALL be registered.
REQ-005 When mem_branch_taken = 1, in any state, pc_src, flush_if_id, flush_id_ex and flush_ex_mem SHALL all be 1 in that same cycle, and the next state SHALL be FLUSH.
REQ-006 A taken branch SHALL take priority over a hazard. In that cycle pc_write = 1, if_id_write = 1, id_ex_bubble = 0, and no stall SHALL be counted.
REQ-007 In RUN or FLUSH, hazard with no taken branch SHALL give pc_write = 0, if_id_write = 0, id_ex_bubble = 1, and the next state SHALL be STALL.
REQ-008 STALL SHALL last exactly one cycle. In STALL with no taken branch: pc_write = 1, if_id_write = 1, id_ex_bubble = 0, hazard ignored, next state RUN.
REQ-009 In FLUSH, hazard detection SHALL apply as in RUN. With no hazard and no taken branch, the next state SHALL be RUN.
REQ-010 Default outputs (RUN, no event): pc_write = 1, if_id_write = 1; all other 1-bit outputs 0.
REQ-011 A load-use hazard SHALL cost exactly one bubble. Back-to-back taken branches SHALL each produce a one-cycle flush.

Reset
REQ-012 While reset = 0: state = RUN, counters = 0, pc_write = 1, if_id_write = 1, all other 1-bit outputs 0, regardless of the other inputs.
REQ-013 Reset asserted mid-STALL or mid-FLUSH SHALL abort the operation immediately (asynchronously).
REQ-014 After reset deasserts, the first rising edge SHALL evaluate from RUN.

Configuration
REQ-015 Macro PIPELINE_CONTROL_PERF_COUNTERS_EN defined:
- stall_count SHALL increment on each cycle where id_ex_bubble = 1.
- flush_count SHALL increment on each cycle where mem_branch_taken = 1.
- Both SHALL saturate at 16'hFFFF.
REQ-016 Macro not defined: stall_count and flush_count SHALL be tied to 0, with no counter flops.

Verification
REQ-017 Load-use: ex_memread = 1, ex_rd = 16, id_rn = 16 -> one cycle with pc_write = 0, if_id_write = 0, id_ex_bubble = 1, then pc_write = 1; stall_count = 1.
REQ-018 XZR: ex_memread = 1, ex_rd = 31, id_rn = 31 -> no stall; pc_write stays 1.
REQ-019 CBZ taken: mem_branch_taken = 1 for one cycle -> pc_src and all three flushes = 1 that cycle, state FLUSH then RUN; flush_count = 1.
REQ-020 Simultaneous events: hazard and mem_branch_taken = 1 in the same cycle -> flushes asserted, id_ex_bubble = 0, stall_count unchanged.
REQ-021 Reset mid-STALL: reset = 0 during STALL -> outputs return to defaults immediately; counters = 0.
REQ-022 Saturation (macro defined): preload stall_count = 16'hFFFE, apply 3 hazards -> stall_count = 16'hFFFF.
